muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer beside the EX stage. Owns the architectural HI/LO registers. Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and serves MFHI/MFLO/MTHI/MTLO. Raises a stall request to the pipeline controller while a HI/LO consumer would see stale data.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.
CNT_WIDTH, 5, iteration counter width (log2 DATA_WIDTH).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
valid_in  input  1  EX holds a valid instruction this cycle.
funct  input  6  funct field of EX instruction (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO; others ignored).
operand_1  input  DATA_WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
operand_2  input  DATA_WIDTH  rt value (multiplier/divisor).
flush  input  1  pipeline flush; cancels in-flight operation.
stall_req  output  1  request to freeze IF..EX.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when HI/LO were written by a mul/div.
hi  output  DATA_WIDTH  current HI register.
lo  output  DATA_WIDTH  current LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, HI=LO=0, busy=0, done=0, stall_req=0, internal accumulators=0.
- States: IDLE, RUN, FIN.
- IDLE: valid_in && funct in {MULT,MULTU,DIV,DIVU} && !flush -> latch magnitudes of operands (two's-complement negate when signed op and sign bit set), record result signs, counter=DATA_WIDTH-1, go RUN. Signed: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
- DIV/DIVU with operand_2==0: no RUN; go FIN with zero-divide flag set; FIN leaves HI/LO unchanged and done=0.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; at counter==0, go FIN.
- FIN: apply sign correction (64-bit negate for product; separate negates for quotient/remainder), write HI/LO (mul: HI=product[63:32], LO=product[31:0]; div: HI=remainder, LO=quotient), done=1 for this cycle, go IDLE.
- Latency: accept edge -> 32 RUN cycles -> FIN cycle; HI/LO visible on the 34th rising edge after acceptance. Divide-by-zero: 2 edges.
- busy=1 in RUN and FIN.
- stall_req (combinational) = (valid_in && funct is any HI/LO funct && state!=IDLE) || (state==IDLE && accepting mul/div this cycle). The issuing instruction stays in EX until FIN; the pipeline releases it on done or the zero-divide FIN. The held instruction must not restart: a start is accepted only in IDLE and only on a cycle where the previous cycle was not FIN.
- MTHI/MTLO: in IDLE with valid_in, write operand_1 to HI/LO at the next edge. While busy, stalled, no write.
- MFHI/MFLO: read hi/lo directly (combinational from register). Stalled while busy.
- flush in any state: go IDLE next edge. HI/LO unchanged, done=0, no write of a pending MTHI/MTLO.
- Simultaneous flush and FIN: flush wins; HI/LO not written.
- Unsigned arithmetic internally on DATA_WIDTH+1 bits for the divide remainder. No overflow traps. Divide of 0x80000000 by -1 yields LO=0x80000000, HI=0.

Test Plan:
- MULT 0xFFFFFFFD x 0x00000007 -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses once, busy low after.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT same operands -> HI=0, LO=1.
- DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
- HI=LO=0x12345678 preset via MTHI/MTLO, then DIVU x/0 -> HI/LO unchanged, done=0, busy for 1 cycle.
- MULT started, MFLO presented at cycle 5 -> stall_req=1 until FIN; flush asserted at cycle 10 -> IDLE next edge, HI/LO keep prior values.
- rst_n driven low mid-RUN (asynchronous, between edges) -> busy, stall_req, HI, LO read 0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  flush;
    logic                  stall_req;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output valid_in, funct, operand_1, operand_2, flush,
        input  stall_req, busy, done, hi, lo
    );

    modport slave (
        input  valid_in, funct, operand_1, operand_2, flush,
        output stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on magnitudes,
// with sign correction applied when the result is written back.
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_ctrl_if.slave bus
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [DATA_WIDTH-1:0] hi_r, lo_r;
    logic                  op_div, div_zero_r, neg_res, neg_rem, prev_fin;

    logic                  is_mul, is_div, is_signed, is_hilo, div_zero, start;
    logic [DATA_WIDTH-1:0] mag1, mag2;
    logic [DATA_WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [DATA_WIDTH-1:0] mul_hi_n, mul_lo_n, div_rem_n, div_quot_n;
    logic                  div_ge;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;
    logic [DATA_WIDTH-1:0] quot_fix, rem_fix;

    // Instruction decode, operand magnitudes and start qualification.
    always_comb begin
        is_mul    = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
        is_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        is_hilo   = is_mul || is_div || (bus.funct == F_MFHI) || (bus.funct == F_MTHI) ||
                    (bus.funct == F_MFLO) || (bus.funct == F_MTLO);
        div_zero  = is_div && (bus.operand_2 == '0);
        mag1      = (is_signed && bus.operand_1[DATA_WIDTH-1]) ? -bus.operand_1 : bus.operand_1;
        mag2      = (is_signed && bus.operand_2[DATA_WIDTH-1]) ? -bus.operand_2 : bus.operand_2;
        // The held issuing instruction is still in EX the cycle after FIN;
        // prev_fin keeps it from being started a second time.
        start     = rst_n && bus.valid_in && (is_mul || is_div) && !bus.flush &&
                    (state == IDLE) && !prev_fin;
    end

    // One iteration step of each algorithm, plus final sign correction.
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + {1'b0, opb};
        mul_hi_n   = acc_lo[0] ? mul_sum[DATA_WIDTH:1] : {1'b0, acc_hi[DATA_WIDTH-1:1]};
        mul_lo_n   = {(acc_lo[0] ? mul_sum[0] : acc_hi[0]), acc_lo[DATA_WIDTH-1:1]};
        div_shift  = {acc_hi, acc_lo[DATA_WIDTH-1]};
        div_diff   = div_shift - {1'b0, opb};
        div_ge     = !div_diff[DATA_WIDTH];
        div_rem_n  = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
        div_quot_n = {acc_lo[DATA_WIDTH-2:0], div_ge};
        prod       = {acc_hi, acc_lo};
        prod_fix   = neg_res ? -prod : prod;
        quot_fix   = neg_res ? -acc_lo : acc_lo;
        rem_fix    = neg_rem ? -acc_hi : acc_hi;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt     = state;
        bus.busy      = (state != IDLE);
        bus.done      = (state == FIN) && !div_zero_r && !bus.flush;
        bus.stall_req = (bus.valid_in && is_hilo && (state != IDLE)) || start;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = div_zero ? FIN : RUN;
                RUN:     if (cnt == '0) state_nxt = FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            op_div     <= 1'b0;
            div_zero_r <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            prev_fin   <= 1'b0;
        end else begin
            prev_fin <= (state == FIN);
            if (start) begin
                cnt        <= CNT_WIDTH'(DATA_WIDTH - 1);
                acc_hi     <= '0;
                acc_lo     <= mag1;
                opb        <= mag2;
                op_div     <= is_div;
                div_zero_r <= div_zero;
                neg_res    <= is_signed && (bus.operand_1[DATA_WIDTH-1] ^ bus.operand_2[DATA_WIDTH-1]);
                neg_rem    <= is_signed && bus.operand_1[DATA_WIDTH-1];
            end else if (state == RUN && !bus.flush) begin
                cnt    <= cnt - 1'b1;
                acc_hi <= op_div ? div_rem_n  : mul_hi_n;
                acc_lo <= op_div ? div_quot_n : mul_lo_n;
            end
        end
    end

    // Architectural HI/LO: mul/div write-back in FIN, MTHI/MTLO in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (!bus.flush) begin
            if (state == FIN && !div_zero_r) begin
                hi_r <= op_div ? rem_fix  : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_r <= op_div ? quot_fix : prod_fix[DATA_WIDTH-1:0];
            end else if (state == IDLE && bus.valid_in) begin
                if (bus.funct == F_MTHI) hi_r <= bus.operand_1;
                if (bus.funct == F_MTLO) lo_r <= bus.operand_1;
            end
        end
    end

    assign bus.hi = hi_r;
    assign bus.lo = lo_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic results, latency, divide by
// zero, flush mid-operation, stall behaviour and asynchronous reset.
module tb_muldiv_ctrl;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_ctrl_if #(.DATA_WIDTH(32)) bus ();

    muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one mul/div from a negedge, hold it in EX until the unit is idle,
    // then release it. Reports accept-to-idle edge count and done pulses.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int dones,
                         output logic stall_pre, output logic stall_post);
        bus.valid_in  = 1'b1;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        #1;
        stall_pre = bus.stall_req;
        edges = 0;
        dones = 0;
        @(posedge clk);
        edges = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (!bus.busy) break;
            @(posedge clk);
            edges++;
        end
        stall_post = bus.stall_req;
        bus.valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.stall_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got busy/done/stall=%b expected 000",
                     {bus.busy, bus.done, bus.stall_req});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_mul();
        int edges, dones;
        logic sp, so;
        do_op(F_MULT, 32'hFFFFFFFD, 32'h00000007, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            errors++;
            $display("FAIL mult_neg: got %h expected FFFFFFFFFFFFFFEB", {bus.hi, bus.lo});
        end
        checks++;
        if (edges !== 34) begin
            errors++;
            $display("FAIL mult_latency: got %0d edges expected 34", edges);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL mult_done_pulses: got %0d expected 1", dones);
        end
        checks++;
        if (sp !== 1'b1) begin
            errors++;
            $display("FAIL accept_stall: got %b expected 1", sp);
        end
        checks++;
        if (so !== 1'b0) begin
            errors++;
            $display("FAIL no_restart_after_fin: stall got %b expected 0", so);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_mult: got %b expected 0", bus.busy);
        end
        do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin
            errors++;
            $display("FAIL multu_max: got %h expected FFFFFFFE00000001", {bus.hi, bus.lo});
        end
        do_op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== 64'h00000000_00000001) begin
            errors++;
            $display("FAIL mult_m1_m1: got %h expected 0000000000000001", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_div();
        int edges, dones;
        logic sp, so;
        do_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL div_neg: got hi/lo %h expected FFFFFFFFFFFFFFFD", {bus.hi, bus.lo});
        end
        do_op(F_DIVU, 32'd100, 32'd7, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL divu_100_7: got hi=%0d lo=%0d expected hi=2 lo=14", bus.hi, bus.lo);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL divu_done_pulses: got %0d expected 1", dones);
        end
        do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, edges, dones, sp, so);
        checks++;
        if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL div_min_m1: got hi/lo %h expected 0000000080000000", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_divzero();
        int edges, dones;
        logic sp, so;
        bus.valid_in  = 1'b1;
        bus.funct     = F_MTHI;
        bus.operand_1 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.funct = F_MTLO;
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
        checks++;
        if ({bus.hi, bus.lo} !== 64'h12345678_12345678) begin
            errors++;
            $display("FAIL mthi_mtlo: got %h expected 1234567812345678", {bus.hi, bus.lo});
        end
        do_op(F_DIVU, 32'd5, 32'd0, edges, dones, sp, so);
        checks++;
        if (edges !== 2) begin
            errors++;
            $display("FAIL divzero_latency: got %0d edges expected 2", edges);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL divzero_done: got %0d pulses expected 0", dones);
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h12345678_12345678) begin
            errors++;
            $display("FAIL divzero_hilo: got %h expected 1234567812345678", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_flush();
        int dones;
        dones = 0;
        bus.valid_in  = 1'b1;
        bus.funct     = F_MULT;
        bus.operand_1 = 32'd3;
        bus.operand_2 = 32'd5;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (c == 5) bus.funct = F_MFLO;
            if (c >= 5) begin
                #1;
                checks++;
                if (bus.stall_req !== 1'b1) begin
                    errors++;
                    $display("FAIL mflo_stall c%0d: got %b expected 1", c, bus.stall_req);
                end
            end
            if (c == 10) bus.flush = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: got %b expected 0", bus.stall_req);
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h12345678_12345678) begin
            errors++;
            $display("FAIL flush_hilo: got %h expected 1234567812345678", {bus.hi, bus.lo});
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL flush_done: got %0d pulses expected 0", dones);
        end
        bus.flush    = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.valid_in  = 1'b1;
        bus.funct     = F_MULT;
        bus.operand_1 = 32'd9;
        bus.operand_2 = 32'd9;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.stall_req, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_status: got busy/stall/done=%b expected 000",
                     {bus.busy, bus.stall_req, bus.done});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            errors++;
            $display("FAIL async_reset_hilo: got %h expected 0", {bus.hi, bus.lo});
        end
        bus.valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.funct     = '0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mul();
        test_div();
        test_divzero();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
